window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//   3x3 neighbourhood generator on the downsampled pixel stream (400x300 active,
//   420x320 incl. blanking, raster order). Buffers two lines and emits one 72-bit
//   window per accepted pixel, with centre coordinates and border flag.
//   Feeds the per-pixel feature detect/filter stages.
// PARAMETERS
//   DATA_W     8    bits per pixel
//   LINE_W     420  beats per line, incl. blanking columns
//   FRAME_H    320  lines per frame, incl. blanking rows
//   ACTIVE_W   400  active columns (cols 0..ACTIVE_W-1)
//   ACTIVE_H   300  active rows (rows 0..ACTIVE_H-1)
// PORTS
//   clock       in   1          system clock, all logic on posedge
//   reset       in   1          synchronous, active-low (0 = reset)
//   valid_in    in   1          pixel beat present
//   data_in     in   DATA_W     pixel value (blanking pixels arrive as 3)
//   blank_in    in   1          upstream blanking flag for this beat
//   window      out  9*DATA_W   window; tap (r,c), r,c in 0..2, at bits [(r*3+c)*DATA_W +: DATA_W]
//   valid_out   out  1          window/coords valid this cycle
//   center_row  out  9          centre pixel row
//   center_col  out  9          centre pixel col
//   border      out  1          centre on active-area edge; window has non-active taps
//   frame_start out  1          pulse with the window centred on (0,0)
//   sync_err    out  1          sticky: blank_in disagreed with internal position
// BEHAVIOUR
// - Reset (reset==0 at posedge) clears all outputs, counters, shift regs and sync_err.
//   Reset wins over valid_in on the same edge. Line-buffer RAM contents need not clear.
// - Position counters col (0..LINE_W-1) and row (0..FRAME_H-1) give the input pixel coordinates.
//   Both advance only on valid_in==1. col wraps to 0 at LINE_W-1 and row increments.
//   At (FRAME_H-1, LINE_W-1) both counters wrap to 0.
// - valid_in==0 changes no state. Gaps of any length are allowed; output equals the gapless case.
// - Two line buffers, LINE_W x DATA_W each, indexed by col:
//   - lb1 holds the previous line; lb0 holds the line before that.
//   - On a beat: read lb0[col], lb1[col]; write lb0[col]<=lb1[col], lb1[col]<=data_in.
//   - Read and write at the same col on the same beat: the read returns the old value.
// - Column shift regs, 3 rows x 3 taps:
//   - Taps shift left on each beat.
//   - New rightmost column: top=lb0[col], mid=lb1[col], bottom=data_in.
// - Window centre for input (row,col):
//   - crow = row-1, or FRAME_H-1 when row==0.
//   - ccol = col-1, or LINE_W-1 when col==0.
//   - Tap (r,c) = pixel(crow-1+r, ccol-1+c).
// - Outputs are registered, latency 1 cycle after the accepted beat:
//   - valid_out=1 iff crow<ACTIVE_H && ccol<ACTIVE_W; otherwise 0.
//   - window, center_row/col, border and frame_start update with valid_out.
//     While valid_out==0 they hold their last values, except frame_start, which is 0.
//   - border = crow==0 || crow==ACTIVE_H-1 || ccol==0 || ccol==ACTIVE_W-1.
//     Border taps may hold blanking (3) or stale previous-frame data; downstream discards them.
//   - frame_start = valid_out && crow==0 && ccol==0.
// - Blanking check on each beat:
//   - exp_blank = row>=ACTIVE_H || col>=ACTIVE_W.
//   - blank_in != exp_blank sets sync_err=1 the next cycle.
//   - sync_err stays set until reset. Counters are not resynchronised.
// - Widths: counters 9 bits. Compares are unsigned. No arithmetic on pixel data.
// TESTING
// - Reset: hold reset=0 for 5 cycles mid-frame, then release.
//   -> valid_out=0, sync_err=0, window=0; first beat is treated as (0,0).
// - Ramp frame: pixel(r,c)=(r*7+c)&8'hFF, gapless.
//   -> after beat (2,2): center=(1,1), window = {16,15,14,9,8,7,2,1,0} (taps (2,2)..(0,0)), border=0.
// - Gaps: same frame with valid_in low on ~50% of random cycles.
//   -> identical sequence of (window, center, border) as the gapless run.
// - Full frames: 3 frames of 420x320 beats.
//   -> per frame: exactly 120000 valid_out, 1396 border=1 and 1 frame_start;
//      no valid_out for blanking centres.
// - Sync error: blank_in=1 at input (5,10).
//   -> sync_err=1 next cycle and stays 1 across frame wrap until reset.
// - Reset mid-line at col 200 with valid_in=1 on the same edge.
//   -> beat ignored, next valid_out only after beat (1,1) of the restart.

Source files
------------

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream input and 3x3 window output bundle for window_3x3_gen.
// The DUT connects through the slave modport; the stream source/sink uses master.
interface window_3x3_gen_if #(
    parameter int unsigned DATA_W = 8
);
    logic                  valid_in;
    logic [DATA_W-1:0]     data_in;
    logic                  blank_in;
    logic [9*DATA_W-1:0]   window;
    logic                  valid_out;
    logic [8:0]            center_row;
    logic [8:0]            center_col;
    logic                  border;
    logic                  frame_start;
    logic                  sync_err;

    modport master (
        output valid_in, data_in, blank_in,
        input  window, valid_out, center_row, center_col, border, frame_start, sync_err
    );

    modport slave (
        input  valid_in, data_in, blank_in,
        output window, valid_out, center_row, center_col, border, frame_start, sync_err
    );
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3x3 tap shift register,
// emitting one registered window per accepted pixel, centred one row/col behind the input.
module window_3x3_gen #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LINE_W   = 420,
    parameter int unsigned FRAME_H  = 320,
    parameter int unsigned ACTIVE_W = 400,
    parameter int unsigned ACTIVE_H = 300
) (
    input  logic            clock,
    input  logic            reset,
    window_3x3_gen_if.slave bus
);
    typedef logic [8:0]                   cnt_t;
    typedef logic [DATA_W-1:0]            pix_t;
    typedef logic [2:0][2:0][DATA_W-1:0]  taps_t;

    localparam cnt_t LAST_COL = cnt_t'(LINE_W - 1);
    localparam cnt_t LAST_ROW = cnt_t'(FRAME_H - 1);
    localparam cnt_t ACT_W    = cnt_t'(ACTIVE_W);
    localparam cnt_t ACT_H    = cnt_t'(ACTIVE_H);
    localparam cnt_t ACT_W_M1 = cnt_t'(ACTIVE_W - 1);
    localparam cnt_t ACT_H_M1 = cnt_t'(ACTIVE_H - 1);

    pix_t lb0_mem [LINE_W];
    pix_t lb1_mem [LINE_W];
    pix_t lb0_rd;
    pix_t lb1_rd;

    cnt_t  col_q, col_d;
    cnt_t  row_q, row_d;
    taps_t tap_q, tap_d;
    cnt_t  crow, ccol;
    logic  win_ok;
    logic  exp_blank;

    logic [9*DATA_W-1:0] window_q, window_d;
    cnt_t  center_row_q, center_row_d;
    cnt_t  center_col_q, center_col_d;
    logic  valid_out_q, valid_out_d;
    logic  border_q, border_d;
    logic  frame_start_q, frame_start_d;
    logic  sync_err_q, sync_err_d;

    // Asynchronous read: the write lands on the clock edge, so a same-beat read sees old data.
    always_comb begin
        lb0_rd = lb0_mem[col_q];
        lb1_rd = lb1_mem[col_q];
    end

    always_comb begin
        crow      = (row_q == '0) ? LAST_ROW : row_q - 9'd1;
        ccol      = (col_q == '0) ? LAST_COL : col_q - 9'd1;
        win_ok    = (crow < ACT_H) && (ccol < ACT_W);
        exp_blank = (row_q >= ACT_H) || (col_q >= ACT_W);

        col_d         = col_q;
        row_d         = row_q;
        tap_d         = tap_q;
        window_d      = window_q;
        center_row_d  = center_row_q;
        center_col_d  = center_col_q;
        border_d      = border_q;
        valid_out_d   = 1'b0;
        frame_start_d = 1'b0;
        sync_err_d    = sync_err_q;

        if (bus.valid_in) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 9'd1;
            end else begin
                col_d = col_q + 9'd1;
            end

            tap_d[0][0] = tap_q[0][1];
            tap_d[0][1] = tap_q[0][2];
            tap_d[0][2] = lb0_rd;
            tap_d[1][0] = tap_q[1][1];
            tap_d[1][1] = tap_q[1][2];
            tap_d[1][2] = lb1_rd;
            tap_d[2][0] = tap_q[2][1];
            tap_d[2][1] = tap_q[2][2];
            tap_d[2][2] = bus.data_in;

            if (bus.blank_in != exp_blank) begin
                sync_err_d = 1'b1;
            end

            if (win_ok) begin
                valid_out_d   = 1'b1;
                center_row_d  = crow;
                center_col_d  = ccol;
                border_d      = (crow == '0) || (crow == ACT_H_M1) ||
                                (ccol == '0) || (ccol == ACT_W_M1);
                frame_start_d = (crow == '0) && (ccol == '0);
                window_d      = {tap_d[2][2], tap_d[2][1], tap_d[2][0],
                                 tap_d[1][2], tap_d[1][1], tap_d[1][0],
                                 tap_d[0][2], tap_d[0][1], tap_d[0][0]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            col_q         <= '0;
            row_q         <= '0;
            tap_q         <= '0;
            window_q      <= '0;
            center_row_q  <= '0;
            center_col_q  <= '0;
            valid_out_q   <= 1'b0;
            border_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            tap_q         <= tap_d;
            window_q      <= window_d;
            center_row_q  <= center_row_d;
            center_col_q  <= center_col_d;
            valid_out_q   <= valid_out_d;
            border_q      <= border_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    // Line buffers are not cleared; a beat coinciding with reset must not write.
    always_ff @(posedge clock) begin
        if (reset && bus.valid_in) begin
            lb0_mem[col_q] <= lb1_rd;
            lb1_mem[col_q] <= bus.data_in;
        end
    end

    assign bus.window      = window_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.center_row  = center_row_q;
    assign bus.center_col  = center_col_q;
    assign bus.border      = border_q;
    assign bus.frame_start = frame_start_q;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized bench for window_3x3_gen on a reduced frame geometry, checked against
// a whole-image reference model (every written pixel kept in a 2-D array).
module tb_window_3x3_gen;
    localparam int DW = 8;
    localparam int LW = 24;
    localparam int FH = 16;
    localparam int AW = 20;
    localparam int AH = 12;
    localparam int WW = 9 * DW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    window_3x3_gen_if #(.DATA_W(DW)) bus ();

    window_3x3_gen #(
        .DATA_W  (DW),
        .LINE_W  (LW),
        .FRAME_H (FH),
        .ACTIVE_W(AW),
        .ACTIVE_H(AH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [DW-1:0] img [FH][LW];
    int m_row = 0;
    int m_col = 0;
    bit exp_err = 1'b0;
    int last_crow = 0;
    int last_ccol = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_v, n_b, n_f;

    task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive a beat at the model position, update the model, compare outputs.
    task automatic beat(input bit v, input bit rnd, input bit bad);
        bit blk, ev, fs, bd;
        logic [DW-1:0] d;
        logic [WW-1:0] expw, mask;
        int crow, ccol;
        blk = (m_row >= AH) || (m_col >= AW);
        if (blk)      d = DW'(3);
        else if (rnd) d = DW'($urandom);
        else          d = DW'((m_row * 7 + m_col) & 255);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.blank_in = blk ^ bad;
        @(posedge clock);
        ev = 1'b0; fs = 1'b0; bd = 1'b0; expw = '0; mask = '0;
        crow = (m_row + FH - 1) % FH;
        ccol = (m_col + LW - 1) % LW;
        if (!reset) begin
            m_row = 0; m_col = 0; exp_err = 1'b0; last_crow = 0; last_ccol = 0;
        end else if (v) begin
            if (bad) exp_err = 1'b1;
            img[m_row][m_col] = d;
            ev = (crow < AH) && (ccol < AW);
            if (ev) begin
                fs = (crow == 0) && (ccol == 0);
                bd = (crow == 0) || (crow == AH - 1) || (ccol == 0) || (ccol == AW - 1);
                for (int tr = 0; tr < 3; tr++) begin
                    for (int tc = 0; tc < 3; tc++) begin
                        int pr, pc;
                        pr = crow - 1 + tr;
                        pc = ccol - 1 + tc;
                        if (pr >= 0 && pr < AH && pc >= 0 && pc < AW) begin
                            expw[(tr * 3 + tc) * DW +: DW] = img[pr][pc];
                            mask[(tr * 3 + tc) * DW +: DW] = '1;
                        end
                    end
                end
                last_crow = crow;
                last_ccol = ccol;
            end
            m_col++;
            if (m_col == LW) begin
                m_col = 0;
                m_row = (m_row + 1) % FH;
            end
        end
        #1;
        check("valid_out", bus.valid_out, ev);
        check("frame_start", bus.frame_start, fs);
        check("sync_err", bus.sync_err, exp_err);
        if (ev) begin
            check("border", bus.border, bd);
            check("window", bus.window & mask, expw & mask);
        end
        check("center_row", bus.center_row, last_crow);
        check("center_col", bus.center_col, last_ccol);
        if (bus.valid_out) n_v++;
        if (bus.valid_out && bus.border) n_b++;
        if (bus.frame_start) n_f++;
    endtask

    initial begin
        logic [WW-1:0] ramp22;
        int n, first;
        ramp22 = {8'd16, 8'd15, 8'd14, 8'd9, 8'd8, 8'd7, 8'd2, 8'd1, 8'd0};
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.blank_in = 1'b0;

        reset = 1'b0;
        repeat (2) beat(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        repeat (LW * 5 + 7) beat(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (5) beat(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        check("rst_window", bus.window, '0);
        check("rst_valid", bus.valid_out, 1'b0);
        check("rst_sync", bus.sync_err, 1'b0);

        n = 0;
        while (n < FH * LW) begin
            if (m_row == 2 && m_col == 2) begin
                beat(1'b1, 1'b0, 1'b0);
                check("ramp22_window", bus.window, ramp22);
                check("ramp22_row", bus.center_row, 1);
                check("ramp22_col", bus.center_col, 1);
                check("ramp22_border", bus.border, 1'b0);
            end else begin
                beat(1'b1, 1'b0, 1'b0);
            end
            n++;
        end

        n = 0;
        while (n < FH * LW) begin
            if ($urandom_range(1, 0) == 1) begin
                beat(1'b0, 1'b0, 1'b0);
            end else begin
                beat(1'b1, 1'b0, 1'b0);
                n++;
            end
        end

        repeat (3) begin
            n_v = 0; n_b = 0; n_f = 0;
            repeat (FH * LW) beat(1'b1, 1'b1, 1'b0);
            check("frame_valid_count", n_v, AW * AH);
            check("frame_border_count", n_b, 2 * AW + 2 * AH - 4);
            check("frame_start_count", n_f, 1);
        end

        while (!(m_row == 5 && m_col == 10)) beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        check("sync_set", bus.sync_err, 1'b1);
        while (!(m_row == 0 && m_col == 0)) beat(1'b1, 1'b1, 1'b0);
        repeat (LW * 2) beat(1'b1, 1'b1, 1'b0);
        check("sync_sticky", bus.sync_err, 1'b1);
        reset = 1'b0;
        beat(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        check("sync_clear", bus.sync_err, 1'b0);

        while (!(m_row == 3 && m_col == 10)) beat(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        beat(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        first = -1;
        for (int k = 0; k < LW + 4; k++) begin
            beat(1'b1, 1'b1, 1'b0);
            if (bus.valid_out && first < 0) first = k;
        end
        check("first_valid_beat", first, LW + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
